// File: rtl/hex_page_scheduler_pkg.sv
// hex_page_scheduler_pkg: shared state encodings and default timing for the HEX page scheduler
package hex_page_scheduler_pkg;
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_BLANK = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;
  localparam int DEF_DWELL     = 50_000_000;
  localparam int DEF_DEB       = 500_000;
  localparam int DEF_BLANK_CYC = 4;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises an active-low key and emits one press pulse per stable press/release cycle
module key_debounce
  import hex_page_scheduler_pkg::*;
#(
  parameter int DEB = DEF_DEB
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEB + 1);
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          held;
  logic          match;
  // held=0 waits for a stable low (press), held=1 waits for a stable high (release)
  assign match = (sync[1] == held);
  // sync chain, stability counter and single-cycle press pulse
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync  <= 2'b11;
      cnt   <= '0;
      held  <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      if (!match) cnt <= '0;
      else if (cnt == CW'(DEB - 1)) begin
        cnt   <= '0;
        held  <= !held;
        press <= !held;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/hex_page_scheduler.sv
// hex_page_scheduler: picks the HEX bank page from key presses, dwell timer or a processor lock
module hex_page_scheduler
  import hex_page_scheduler_pkg::*;
#(
  parameter int NPAGES    = 4,
  parameter int PW        = 2,
  parameter int DWELL     = DEF_DWELL,
  parameter int DEB       = DEF_DEB,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              key_n,
  input  logic              auto_en,
  input  logic [NPAGES-1:0] page_mask,
  input  logic              cpu_req,
  input  logic [PW-1:0]     cpu_page,
  output logic              cpu_ack,
  output logic [PW-1:0]     page_sel,
  output logic              blank,
  output logic              page_chg
);
  localparam int DW = $clog2(DWELL + 1);
  localparam int BW = $clog2(BLANK_CYC + 1);
  state_t        state, state_n;
  logic [DW-1:0] dwell, dwell_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [PW-1:0] page_n, nxt_page, cpu_clamp;
  logic          blank_n, ack_n, chg_n;
  logic          press, found, timeout, advance;
  int            idx;
  key_debounce #(.DEB(DEB)) u_deb (
    .Clock (Clock),
    .Resetn(Resetn),
    .key_n (key_n),
    .press (press)
  );
  assign cpu_clamp = (int'(cpu_page) >= NPAGES) ? PW'(NPAGES - 1) : cpu_page;
  assign timeout   = auto_en && (dwell == DW'(DWELL - 1));
  assign advance   = (press || timeout) && found;
  // first enabled page after the current one; scanning far-to-near leaves the nearest winner
  always_comb begin
    nxt_page = page_sel;
    found    = 1'b0;
    idx      = 0;
    for (int i = NPAGES - 1; i >= 1; i--) begin
      idx = (int'(page_sel) + i) % NPAGES;
      if (page_mask[PW'(idx)]) begin
        nxt_page = PW'(idx);
        found    = 1'b1;
      end
    end
  end
  // next state and next registered outputs; cpu_req outranks key and timer
  always_comb begin
    state_n = state;
    page_n  = page_sel;
    blank_n = blank;
    ack_n   = cpu_ack;
    chg_n   = 1'b0;
    bcnt_n  = bcnt;
    dwell_n = dwell;
    case (state)
      ST_LOCK: begin
        dwell_n = '0;
        if (!cpu_req) begin
          state_n = ST_BLANK;
          ack_n   = 1'b0;
          blank_n = 1'b1;
          bcnt_n  = BW'(BLANK_CYC - 1);
        end else begin
          page_n  = cpu_clamp;
          chg_n   = cpu_clamp != page_sel;
          blank_n = 1'b0;
        end
      end
      ST_BLANK: begin
        dwell_n = '0;
        if (cpu_req) begin
          state_n = ST_LOCK;
          ack_n   = 1'b1;
          page_n  = cpu_clamp;
          chg_n   = cpu_clamp != page_sel;
          blank_n = 1'b0;
        end else if (bcnt == '0) begin
          state_n = ST_RUN;
          blank_n = page_mask == '0;
        end else begin
          blank_n = 1'b1;
          bcnt_n  = bcnt - 1'b1;
        end
      end
      default: begin
        if (cpu_req) begin
          state_n = ST_LOCK;
          ack_n   = 1'b1;
          page_n  = cpu_clamp;
          chg_n   = cpu_clamp != page_sel;
          blank_n = 1'b0;
          dwell_n = '0;
        end else if (advance) begin
          state_n = ST_BLANK;
          page_n  = nxt_page;
          chg_n   = 1'b1;
          blank_n = 1'b1;
          bcnt_n  = BW'(BLANK_CYC - 1);
          dwell_n = '0;
        end else begin
          state_n = ST_RUN;
          blank_n = page_mask == '0;
          dwell_n = (!auto_en || page_mask == '0 || timeout) ? '0 : dwell + 1'b1;
        end
      end
    endcase
  end
  // state, counters and all outputs registered together
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= ST_BLANK;
      page_sel <= '0;
      blank    <= 1'b1;
      cpu_ack  <= 1'b0;
      page_chg <= 1'b0;
      bcnt     <= BW'(BLANK_CYC - 1);
      dwell    <= '0;
    end else begin
      state    <= state_n;
      page_sel <= page_n;
      blank    <= blank_n;
      cpu_ack  <= ack_n;
      page_chg <= chg_n;
      bcnt     <= bcnt_n;
      dwell    <= dwell_n;
    end
  end
endmodule

// File: tb/tb_hex_page_scheduler.sv
// tb_hex_page_scheduler: scenario tasks with a page-change scoreboard for hex_page_scheduler
module tb_hex_page_scheduler;
  logic       clk = 1'b0;
  logic       rst_n, key_n, auto_en, cpu_req;
  logic [3:0] page_mask;
  logic [1:0] cpu_page, page_sel;
  logic       cpu_ack, blank, page_chg;
  int         n_cmp = 0, n_err = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  hex_page_scheduler #(.NPAGES(4), .PW(2), .DWELL(10), .DEB(3), .BLANK_CYC(2)) dut (
    .Clock    (clk),
    .Resetn   (rst_n),
    .key_n    (key_n),
    .auto_en  (auto_en),
    .page_mask(page_mask),
    .cpu_req  (cpu_req),
    .cpu_page (cpu_page),
    .cpu_ack  (cpu_ack),
    .page_sel (page_sel),
    .blank    (blank),
    .page_chg (page_chg)
  );

  // scoreboard: every page_chg pulse must match the oldest expected page
  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_n && page_chg) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL chg_unexpected: page_sel=%0d with no change expected", page_sel);
      end else begin
        e = exp_q.pop_front();
        if (page_sel !== e) begin
          n_err++;
          $display("FAIL chg_page: got %0d expected %0d", page_sel, e);
        end
      end
    end
  end

  task automatic wait_chg(input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!page_chg && n < lim);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; key_n = 1'b1; auto_en = 1'b0; cpu_req = 1'b0; cpu_page = 2'd0; page_mask = 4'hF;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({page_sel, blank, cpu_ack, page_chg} !== {2'd0, 3'b100}) begin
      n_err++;
      $display("FAIL reset_vals: got sel=%0d blank=%b ack=%b chg=%b", page_sel, blank, cpu_ack, page_chg);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (blank !== 1'b1) begin n_err++; $display("FAIL reset_blank1: got %b expected 1", blank); end
    @(negedge clk);
    n_cmp++;
    if ({page_sel, blank, cpu_ack} !== {2'd0, 2'b00}) begin
      n_err++;
      $display("FAIL reset_run: got sel=%0d blank=%b ack=%b expected 0/0/0", page_sel, blank, cpu_ack);
    end
  endtask

  task automatic test_key;
    int n, c;
    exp_q.push_back(2'd1);
    key_n = 1'b0;
    wait_chg(20, n);
    n_cmp++;
    if (!page_chg || n != 6) begin n_err++; $display("FAIL key_latency: got %0d cycles chg=%b expected 6", n, page_chg); end
    n_cmp++;
    if (blank !== 1'b1) begin n_err++; $display("FAIL key_blank_a: got %b expected 1", blank); end
    @(negedge clk);
    n_cmp++;
    if (blank !== 1'b1) begin n_err++; $display("FAIL key_blank_b: got %b expected 1", blank); end
    @(negedge clk);
    n_cmp++;
    if (blank !== 1'b0) begin n_err++; $display("FAIL key_blank_end: got %b expected 0", blank); end
    c = 0;
    repeat (20) begin @(negedge clk); if (page_chg) c++; end
    n_cmp++;
    if (c != 0) begin n_err++; $display("FAIL key_hold: got %0d changes expected 0", c); end
    key_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_auto;
    int n, c;
    exp_q.push_back(2'd3); exp_q.push_back(2'd1); exp_q.push_back(2'd3); exp_q.push_back(2'd1);
    page_mask = 4'b1010; auto_en = 1'b1;
    wait_chg(30, n);
    n_cmp++;
    if (!page_chg || n != 10) begin n_err++; $display("FAIL auto_first: got %0d cycles chg=%b expected 10", n, page_chg); end
    for (int k = 0; k < 3; k++) begin
      wait_chg(30, n);
      n_cmp++;
      if (!page_chg || n != 12) begin n_err++; $display("FAIL auto_period: step %0d got %0d cycles expected 12", k, n); end
    end
    page_mask = 4'b0010;
    c = 0;
    repeat (30) begin @(negedge clk); if (page_chg) c++; end
    n_cmp++;
    if (c != 0 || page_sel !== 2'd1 || blank !== 1'b0) begin
      n_err++;
      $display("FAIL auto_single: got changes=%0d sel=%0d blank=%b expected 0/1/0", c, page_sel, blank);
    end
  endtask

  task automatic test_lock;
    int n, c;
    page_mask = 4'hF;
    exp_q.push_back(2'd2);
    wait_chg(30, n);
    n_cmp++;
    if (!page_chg || blank !== 1'b1) begin n_err++; $display("FAIL lock_pre: got chg=%b blank=%b expected 1/1", page_chg, blank); end
    cpu_req = 1'b1; cpu_page = 2'd2;
    @(negedge clk);
    n_cmp++;
    if ({cpu_ack, page_sel, blank, page_chg} !== {1'b1, 2'd2, 2'b00}) begin
      n_err++;
      $display("FAIL lock_grant: got ack=%b sel=%0d blank=%b chg=%b expected 1/2/0/0", cpu_ack, page_sel, blank, page_chg);
    end
    c = 0;
    key_n = 1'b0;
    repeat (10) begin @(negedge clk); if (page_chg) c++; end
    key_n = 1'b1;
    repeat (15) begin @(negedge clk); if (page_chg) c++; end
    n_cmp++;
    if (c != 0 || cpu_ack !== 1'b1 || page_sel !== 2'd2) begin
      n_err++;
      $display("FAIL lock_hold: got changes=%0d ack=%b sel=%0d expected 0/1/2", c, cpu_ack, page_sel);
    end
    exp_q.push_back(2'd3);
    cpu_page = 2'd3;
    @(negedge clk);
    n_cmp++;
    if (page_sel !== 2'd3 || page_chg !== 1'b1) begin
      n_err++;
      $display("FAIL lock_follow: got sel=%0d chg=%b expected 3/1", page_sel, page_chg);
    end
  endtask

  task automatic test_release;
    int n;
    exp_q.push_back(2'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cpu_ack, blank, page_sel} !== {2'b01, 2'd3}) begin
      n_err++;
      $display("FAIL rel_drop: got ack=%b blank=%b sel=%0d expected 0/1/3", cpu_ack, blank, page_sel);
    end
    @(negedge clk);
    n_cmp++;
    if (blank !== 1'b1) begin n_err++; $display("FAIL rel_blank_b: got %b expected 1", blank); end
    @(negedge clk);
    n_cmp++;
    if (blank !== 1'b0 || page_sel !== 2'd3) begin n_err++; $display("FAIL rel_run: got blank=%b sel=%0d expected 0/3", blank, page_sel); end
    wait_chg(20, n);
    n_cmp++;
    if (!page_chg || n != 10) begin n_err++; $display("FAIL rel_wrap: got %0d cycles chg=%b expected 10", n, page_chg); end
    auto_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n;
    exp_q.push_back(2'd2);
    cpu_req = 1'b1; cpu_page = 2'd2;
    @(negedge clk);
    n_cmp++;
    if (cpu_ack !== 1'b1) begin n_err++; $display("FAIL mid_lock_ack: got %b expected 1", cpu_ack); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({page_sel, blank, cpu_ack, page_chg} !== {2'd0, 3'b100}) begin
      n_err++;
      $display("FAIL mid_lock_reset: got sel=%0d blank=%b ack=%b chg=%b", page_sel, blank, cpu_ack, page_chg);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    key_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({page_sel, blank, cpu_ack, page_chg} !== {2'd0, 3'b100}) begin
      n_err++;
      $display("FAIL mid_deb_reset: got sel=%0d blank=%b ack=%b chg=%b", page_sel, blank, cpu_ack, page_chg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(2'd1);
    wait_chg(20, n);
    n_cmp++;
    if (!page_chg || n != 6) begin n_err++; $display("FAIL mid_deb_press: got %0d cycles chg=%b expected 6", n, page_chg); end
    key_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_key();
    test_auto();
    test_lock();
    test_release();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
